// File: rtl/ldm_axi_stream_mover.sv
// ldm_axi_stream_mover
//
// Purpose: bus-side initiator for the LSU AXI_LDM port A. It accepts one command
// (base address, word count, direction) and then either writes a valid/ready
// input stream into the banked LDM or reads LDM words back out as a valid/ready
// output stream. It is used to load feature maps and weights before each layer.
//
// Ports:
//   CLK, RST                     clock, asynchronous active-low reset
//   cmd_valid_in / cmd_ready_out command handshake (ready only while idle)
//   cmd_rd_in                    1 = LDM -> stream, 0 = stream -> LDM
//   cmd_addr_in                  start address {bank, word}
//   cmd_len_in                   word count, 0 .. 2^ADDR_W
//   s_data_in/s_valid_in/s_ready_out    write stream
//   m_data_out/m_valid_out/m_ready_in   read stream, m_last_out on final word
//   AXI_LDM_*                    registered port A to the LSU (douta 1 cycle after ena)
//   busy_out                     command in progress, port A is owned by this block
//   done_out                     one-cycle pulse when a command completes
module ldm_axi_stream_mover #(
   parameter int DATA_WIDTH   = 16,
   parameter int LDM_NUM_BITS = 2,
   parameter int LDM_AD_WIDTH = 6,
   parameter int RD_BUF_DEPTH = 4
) (
   input  logic                                  CLK,
   input  logic                                  RST,
   input  logic                                  cmd_valid_in,
   output logic                                  cmd_ready_out,
   input  logic                                  cmd_rd_in,
   input  logic [LDM_NUM_BITS+LDM_AD_WIDTH-1:0]  cmd_addr_in,
   input  logic [LDM_NUM_BITS+LDM_AD_WIDTH:0]    cmd_len_in,
   input  logic [DATA_WIDTH-1:0]                 s_data_in,
   input  logic                                  s_valid_in,
   output logic                                  s_ready_out,
   output logic [DATA_WIDTH-1:0]                 m_data_out,
   output logic                                  m_valid_out,
   input  logic                                  m_ready_in,
   output logic                                  m_last_out,
   output logic [LDM_NUM_BITS+LDM_AD_WIDTH-1:0]  AXI_LDM_addra_out,
   output logic [DATA_WIDTH-1:0]                 AXI_LDM_dina_out,
   output logic                                  AXI_LDM_ena_out,
   output logic                                  AXI_LDM_wea_out,
   input  logic [DATA_WIDTH-1:0]                 AXI_LDM_douta_in,
   output logic                                  busy_out,
   output logic                                  done_out
);

   localparam int ADDR_W = LDM_NUM_BITS + LDM_AD_WIDTH;
   localparam int PTR_W  = $clog2(RD_BUF_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [ADDR_W:0]  LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [CNT_W:0]   OCC_FULL = (CNT_W+1)'(RD_BUF_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [1:0]            state_reg;
   logic [ADDR_W-1:0]     base_reg;
   logic [ADDR_W:0]       len_reg;
   logic [ADDR_W:0]       cnt_reg;      // words accepted (WR) or reads issued (RD)
   logic [ADDR_W:0]       popped_reg;   // words handed out on the read stream
   logic [ADDR_W-1:0]     addra_reg;
   logic [DATA_WIDTH-1:0] dina_reg;
   logic                  ena_reg;
   logic                  wea_reg;
   logic                  cap_valid_reg; // douta_in carries read data this cycle

   logic [DATA_WIDTH-1:0] buf_mem [RD_BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [CNT_W-1:0]      buf_count_reg;

   logic                  cmd_fire;
   logic                  s_fire;
   logic                  pop;
   logic                  rd_issue;
   logic [CNT_W:0]        occ;

   assign cmd_ready_out = (state_reg == IDLE);
   assign cmd_fire      = cmd_valid_in && cmd_ready_out;
   assign s_ready_out   = (state_reg == WR) && (cnt_reg < len_reg);
   assign s_fire        = s_ready_out && s_valid_in;

   assign m_valid_out   = (buf_count_reg != '0);
   assign m_data_out    = m_valid_out ? buf_mem[rd_ptr_reg] : '0;
   assign m_last_out    = m_valid_out && (popped_reg == (len_reg - LEN_ONE));
   assign pop           = m_valid_out && m_ready_in;

   // Every read that has been issued but not yet popped needs a buffer slot:
   // the one on the port now, the one returning on douta, and the buffered ones.
   // A pop in the same cycle is not credited, which keeps the check simple and
   // still allows one word per cycle with a 4-entry buffer.
   assign occ      = {1'b0, buf_count_reg}
                   + (CNT_W+1)'(ena_reg && !wea_reg)
                   + (CNT_W+1)'(cap_valid_reg);
   assign rd_issue = (state_reg == RD) && (cnt_reg < len_reg) && (occ < OCC_FULL);

   assign AXI_LDM_addra_out = addra_reg;
   assign AXI_LDM_dina_out  = dina_reg;
   assign AXI_LDM_ena_out   = ena_reg;
   assign AXI_LDM_wea_out   = wea_reg;
   assign busy_out          = (state_reg != IDLE);
   assign done_out          = (state_reg == DONE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg     <= IDLE;
         base_reg      <= '0;
         len_reg       <= '0;
         cnt_reg       <= '0;
         popped_reg    <= '0;
         addra_reg     <= '0;
         dina_reg      <= '0;
         ena_reg       <= 1'b0;
         wea_reg       <= 1'b0;
         cap_valid_reg <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         buf_count_reg <= '0;
      end else begin
         ena_reg       <= 1'b0;
         wea_reg       <= 1'b0;
         cap_valid_reg <= ena_reg && !wea_reg;

         case (state_reg)
            IDLE: begin
               if (cmd_fire) begin
                  base_reg   <= cmd_addr_in;
                  len_reg    <= cmd_len_in;
                  popped_reg <= '0;
                  cnt_reg    <= '0;
                  if (cmd_len_in == '0) begin
                     state_reg <= DONE;
                  end else if (cmd_rd_in) begin
                     // The first read is issued together with the command
                     // so the first word reaches the stream two cycles into RD.
                     state_reg <= RD;
                     ena_reg   <= 1'b1;
                     addra_reg <= cmd_addr_in;
                     cnt_reg   <= LEN_ONE;
                  end else begin
                     state_reg <= WR;
                  end
               end
            end
            WR: begin
               if (s_fire) begin
                  ena_reg   <= 1'b1;
                  wea_reg   <= 1'b1;
                  addra_reg <= base_reg + cnt_reg[ADDR_W-1:0];
                  dina_reg  <= s_data_in;
                  cnt_reg   <= cnt_reg + LEN_ONE;
                  if ((cnt_reg + LEN_ONE) == len_reg) begin
                     state_reg <= DONE;
                  end
               end
            end
            RD: begin
               if (rd_issue) begin
                  ena_reg   <= 1'b1;
                  addra_reg <= base_reg + cnt_reg[ADDR_W-1:0];
                  cnt_reg   <= cnt_reg + LEN_ONE;
               end
               if (pop) begin
                  popped_reg <= popped_reg + LEN_ONE;
                  if ((popped_reg + LEN_ONE) == len_reg) begin
                     state_reg <= DONE;
                  end
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         if (cap_valid_reg) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({cap_valid_reg, pop})
            2'b10:   buf_count_reg <= buf_count_reg + CNT_ONE;
            2'b01:   buf_count_reg <= buf_count_reg - CNT_ONE;
            default: buf_count_reg <= buf_count_reg;
         endcase
      end
   end

   // Buffer storage needs no reset: pointers and count are cleared and the
   // output data is forced to zero while the buffer is empty.
   always_ff @(posedge CLK) begin
      if (cap_valid_reg) begin
         buf_mem[wr_ptr_reg] <= AXI_LDM_douta_in;
      end
   end

endmodule
